// File: rtl/vote_pkg.sv
// Shared state encoding and idle-counter width for the vote collector.
package vote_pkg;

    typedef enum logic [1:0] {
        VC_EMPTY = 2'd0,
        VC_HAS1  = 2'd1,
        VC_HAS2  = 2'd2,
        VC_FULL  = 2'd3
    } vc_state_e;

    localparam int unsigned VC_CNT_W = 8;

endpackage

// File: rtl/vote_idle_timer.sv
// Saturating idle counter; tc_o flags the idle cycle on which the count would reach Limit.
module vote_idle_timer
    import vote_pkg::*;
#(
    parameter int unsigned Limit = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [VC_CNT_W-1:0] LimitC = VC_CNT_W'(Limit);

    logic [VC_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc_o  = en_i && (cnt_q == LimitC - 1'b1);
        cnt_d = cnt_q;
        // Terminal count also clears, since the owner drops back to its idle state.
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Collects three serial votes into vote0..vote2 behind a valid/ready handshake.
// Optional idle timeout enabled by defining VOTE_COLLECTOR_TIMEOUT_EN.
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_val,
    output logic in_rdy,
    input  logic in_vote,
    output logic out_val,
    input  logic out_rdy,
    output logic vote0,
    output logic vote1,
    output logic vote2,
    output logic timeout
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    vc_state_e state_q, state_d;
    logic      accept;
    logic      idle_en;
    logic      tmo_fire;
    logic      vote0_q, vote1_q, vote2_q;

    assign accept  = in_val && in_rdy;
    assign idle_en = ((state_q == VC_HAS1) || (state_q == VC_HAS2)) && !accept;

`ifdef VOTE_COLLECTOR_TIMEOUT_EN
    logic timeout_q;

    vote_idle_timer #(
        .Limit (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (!idle_en),
        .en_i   (idle_en),
        .tc_o   (tmo_fire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_fire;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= VC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VC_EMPTY: if (accept) state_d = VC_HAS1;
            VC_HAS1: begin
                if (accept) state_d = VC_HAS2;
                else if (tmo_fire) state_d = VC_EMPTY;
            end
            VC_HAS2: begin
                if (accept) state_d = VC_FULL;
                else if (tmo_fire) state_d = VC_EMPTY;
            end
            VC_FULL: begin
                // A new first vote may land on the same edge the held set is consumed.
                if (out_rdy) state_d = accept ? VC_HAS1 : VC_EMPTY;
            end
            default: state_d = VC_EMPTY;
        endcase
    end

    always_comb begin
        in_rdy  = (state_q != VC_FULL) || out_rdy;
        out_val = (state_q == VC_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vote0_q <= 1'b0;
            vote1_q <= 1'b0;
            vote2_q <= 1'b0;
        end else if (accept) begin
            if ((state_q == VC_EMPTY) || (state_q == VC_FULL)) vote0_q <= in_vote;
            if (state_q == VC_HAS1) vote1_q <= in_vote;
            if (state_q == VC_HAS2) vote2_q <= in_vote;
        end
    end

    assign vote0 = vote0_q;
    assign vote1 = vote1_q;
    assign vote2 = vote2_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: stimulus pushes expected sets, a monitor checks each handshake.
module tb_vote_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_val = 1'b0;
    logic in_rdy;
    logic in_vote = 1'b0;
    logic out_val;
    logic out_rdy = 1'b0;
    logic vote0, vote1, vote2;
    logic timeout;

    int checks = 0;
    int errors = 0;
    int n_timeouts = 0;
    logic [2:0] exp_q[$];

    vote_collector #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_vote (in_vote),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .vote0   (vote0),
        .vote1   (vote1),
        .vote2   (vote2),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v);
        in_val  = 1'b1;
        in_vote = v;
        tick();
        in_val  = 1'b0;
    endtask

    // Monitor: a handshake completes at the next edge whenever out_val && out_rdy now.
    always @(negedge clk) begin
        if (rst_n && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_set", 1, 0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("set_votes", int'({vote0, vote1, vote2}), int'(e));
            end
        end
        if (timeout) n_timeouts++;
    end

    initial begin
        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_val", out_val, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_votes", {vote0, vote1, vote2}, 0);
        chk("rst_timeout", timeout, 0);

        // Set 1,0,1 with downstream stalled, then held for 5 cycles
        exp_q.push_back(3'b101);
        send(1'b1);
        send(1'b0);
        chk("t1_not_yet", out_val, 0);
        send(1'b1);
        chk("t1_out_val", out_val, 1);
        chk("t1_in_rdy", in_rdy, 0);
        in_val  = 1'b1;
        in_vote = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_val", out_val, 1);
            chk("t1_hold_votes", {vote0, vote1, vote2}, 3'b101);
            chk("t1_hold_rdy", in_rdy, 0);
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        tick();
        chk("t1_consumed", out_val, 0);

        // Back-to-back stream 1,1,0,0,0,1 with downstream always ready
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b001);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        chk("t2_full_a", out_val, 1);
        chk("t2_rdy_passthru", in_rdy, 1);
        send(1'b0);
        chk("t2_overlap", out_val, 0);
        send(1'b0);
        send(1'b1);
        chk("t2_full_b", out_val, 1);
        tick();
        chk("t2_drained", out_val, 0);

        // Reset mid-set, then a clean set 0,1,1
        out_rdy = 1'b0;
        send(1'b1);
        send(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t3_out_val", out_val, 0);
        chk("t3_votes", {vote0, vote1, vote2}, 0);
        chk("t3_timeout", timeout, 0);
        chk("t3_in_rdy", in_rdy, 1);
        exp_q.push_back(3'b011);
        send(1'b0);
        send(1'b1);
        send(1'b1);
        chk("t3_full", out_val, 1);
        out_rdy = 1'b1;
        tick();

        // Gapped input 1,0,1,0,1 valid pattern -> one set 0,1,0
        exp_q.push_back(3'b010);
        send(1'b0);
        tick();
        send(1'b1);
        tick();
        chk("t4_before", out_val, 0);
        send(1'b0);
        chk("t4_after", out_val, 1);
        tick();
        chk("t4_drained", out_val, 0);
        out_rdy = 1'b0;

`ifdef VOTE_COLLECTOR_TIMEOUT_EN
        // One vote, 4 idle cycles -> timeout pulse, back to EMPTY
        send(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_pulse_yet", timeout, 0);
        end
        tick();
        chk("t5_pulse", timeout, 1);
        tick();
        chk("t5_pulse_one_cycle", timeout, 0);
        exp_q.push_back(3'b101);
        send(1'b1);
        send(1'b0);
        chk("t5_empty_after_tmo", out_val, 0);
        send(1'b1);
        chk("t5_full", out_val, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        // Vote on idle cycle 4 wins over the timeout
        send(1'b0);
        tick();
        tick();
        tick();
        send(1'b1);
        chk("t5_accept_wins", timeout, 0);
        tick();
        chk("t5_no_late_pulse", timeout, 0);
        exp_q.push_back(3'b011);
        send(1'b1);
        chk("t5_has2_then_full", out_val, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("timeout_count", n_timeouts, 1);
`else
        // Partial set held indefinitely
        send(1'b1);
        for (int i = 0; i < 100; i++) tick();
        chk("t6_out_val", out_val, 0);
        chk("t6_in_rdy", in_rdy, 1);
        exp_q.push_back(3'b100);
        send(1'b0);
        send(1'b0);
        chk("t6_full", out_val, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("timeout_count", n_timeouts, 0);
`endif

        tick();
        chk("sets_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
